demux8_buf: RTL

DEMUX8_BUF -- requirements
Module: demux8_buf

---
 rtl/demux8_buf.sv | 110 +++++++++++
 1 files changed

// File: rtl/demux8_buf.sv
// 1-to-8 word distributor: one valid/ready input stream feeding eight
// single-entry output slots, each with its own valid/ready handshake.

module demux8_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A load in the same edge as a drain wins, keeping the slot FULL at
    // one word per clock. Load is never raised while flush is high.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else if (load_i) begin
            state_d = FULL;
            data_d  = data_i;
        end else if (state_q == FULL && drain_i) begin
            state_d = EMPTY;
        end
    end

    assign data_o  = data_q;
    assign valid_o = (state_q == FULL);

endmodule

module demux8_buf #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
    output logic [15:0]        accept_count
);

    logic        accept;
    logic [7:0]  load;
    logic [15:0] count_q, count_d;

    // Ready only looks at the addressed slot, never at in_valid.
    assign in_ready = !reset && !flush &&
                      (!out_valid[in_sel] || out_ready[in_sel]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        load         = '0;
        load[in_sel] = accept;
    end

    for (genvar i = 0; i < 8; i++) begin : g_slot
        demux8_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .flush_i (flush),
            .load_i  (load[i]),
            .drain_i (out_ready[i]),
            .data_i  (in_data),
            .data_o  (out_data[WIDTH*i +: WIDTH]),
            .valid_o (out_valid[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    always_comb begin
        count_d = count_q;
        if (accept) count_d = count_q + 16'd1;
    end

    assign accept_count = count_q;

endmodule
